// File: rtl/fifo_rd_arbiter.sv
// Round-robin arbiter for the read port of one synchronous FIFO shared by
// NUM_REQ consumers. One requester owns the FIFO for a burst of up to
// MAX_BURST pops. Each popped word is returned one cycle later, tagged with
// the index of the requester that owns it.
//
// Handshake: out_valid is a one-cycle strobe with no ready/back-pressure.
// out_data/out_id are meaningful only while out_valid is high, and the
// consumer must take the word in that same cycle. On the FIFO side,
// fifo_rd_en pops one word on the rising edge and the word appears on
// fifo_rdata in the following cycle.
module fifo_rd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic                  dbg_state
);

  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_BURST - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [ID_WIDTH-1:0]  LAST_ID  = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [ID_WIDTH-1:0]  ID_ONE   = ID_WIDTH'(1);

  logic [0:0]           state;
  logic [ID_WIDTH-1:0]  owner;
  logic [ID_WIDTH-1:0]  rr_ptr;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 rd_d1;
  logic [ID_WIDTH-1:0]  id_d1;

  logic [ID_WIDTH-1:0]  sel_idx;
  logic                 sel_any;
  logic [ID_WIDTH-1:0]  scan_idx;
  logic                 pop;
  logic                 burst_exit;
  logic [ID_WIDTH-1:0]  next_ptr;

  // Round-robin search: first requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    sel_idx  = rr_ptr;
    sel_any  = 1'b0;
    scan_idx = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!sel_any && req[scan_idx]) begin
        sel_any = 1'b1;
        sel_idx = scan_idx;
      end
      scan_idx = (scan_idx == LAST_ID) ? '0 : scan_idx + ID_ONE;
    end
  end

  // Pop and burst-exit decisions; an empty FIFO or a dropped request ends the
  // burst without a pop, the MAX_BURST-th pop ends it after popping.
  always_comb begin
    pop        = (state == S_BURST) && req[owner] && !fifo_empty;
    burst_exit = (state == S_BURST) && (!pop || (cnt == LAST_CNT));
    next_ptr   = (owner == LAST_ID) ? '0 : owner + ID_ONE;
  end

  // Grant is decoded purely from registered state, so it never glitches.
  always_comb begin
    gnt = '0;
    if (state == S_BURST) begin
      gnt[owner] = 1'b1;
    end
  end

  // Arbitration state: IDLE picks an owner, BURST counts pops until an exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_any && !fifo_empty) begin
            state <= S_BURST;
            owner <= sel_idx;
            cnt   <= '0;
          end
        end
        S_BURST: begin
          if (pop) begin
            cnt <= cnt + CNT_ONE;
          end
          if (burst_exit) begin
            state  <= S_IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Output tag pipeline: aligns the owner index with the FIFO's one-cycle read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1 <= 1'b0;
      id_d1 <= '0;
    end else begin
      rd_d1 <= fifo_rd_en;
      id_d1 <= owner;
    end
  end

  assign fifo_rd_en = pop;
  assign out_valid  = rd_d1;
  assign out_id     = id_d1;
  assign out_data   = fifo_rdata;
  assign dbg_state  = (state == S_BURST);

endmodule

// File: doc/fifo_rd_arbiter.md
# fifo_rd_arbiter

Round-robin arbiter that shares the read port of one synchronous power-of-two FIFO among NUM_REQ consumers. It grants the FIFO to one requester at a time for a bounded burst and drives the FIFO's `rd_en`. It returns each popped word tagged with the owning requester's index. It sits between the FIFO's read side (`rd_en`/`empty`/read data) and the downstream consumer logic.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- DATA_WIDTH, 8: FIFO word width.
- MAX_BURST, 4: maximum pops per grant, 1..255.
- ID_WIDTH, derived, $clog2(NUM_REQ): width of `out_id`.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester read request; level-sensitive.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdata  in  DATA_WIDTH  FIFO read data; valid the cycle after `fifo_rd_en`.
- fifo_rd_en  out  1  FIFO pop strobe.
- gnt  out  NUM_REQ  one-hot grant (registered); all zero when idle.
- out_valid  out  1  `out_data`/`out_id` valid this cycle.
- out_data  out  DATA_WIDTH  popped word; pass-through of `fifo_rdata`.
- out_id  out  ID_WIDTH  index of the requester that owns `out_data`.

## Operation
- State machine with two states, IDLE and BURST. Registers:
  - `owner` (ID_WIDTH bits)
  - `rr_ptr` (ID_WIDTH bits)
  - `cnt` ($clog2(MAX_BURST+1) bits)
  - `rd_d1`
  - `id_d1`
- Selection is combinational: the first index with `req` set, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- IDLE:
  - If `req` != 0 and `fifo_empty` = 0: go to BURST, `owner` <= selected index, `cnt` <= 0.
  - Otherwise stay in IDLE.
  - No grant is ever issued while the FIFO is empty.
- BURST:
  - `gnt` = one-hot(`owner`).
  - `fifo_rd_en` = `req[owner]` & !`fifo_empty` (combinational).
  - On each pop, `cnt` <= `cnt`+1.
- BURST exit to IDLE happens on the first of:
  - a pop while `cnt` == MAX_BURST-1 (the last pop is still performed);
  - `req[owner]` = 0 (no pop that cycle);
  - `fifo_empty` = 1 (no pop that cycle).
- On every exit, `rr_ptr` <= (`owner`+1) mod NUM_REQ. The wrap from NUM_REQ-1 goes to 0. For non-power-of-two NUM_REQ the modulo is explicit.
- The same requester can be re-granted only after every other active requester has been offered a grant.
- Output path:
  - `rd_d1` <= `fifo_rd_en`; `id_d1` <= `owner`.
  - `out_valid` = `rd_d1`; `out_id` = `id_d1`; `out_data` = `fifo_rdata`.
  - There is no back-pressure; the consumer must accept `out_valid` every cycle.
- Simultaneous events:
  - If the owner drops `req` in the same cycle the FIFO goes empty, there is one exit and `rr_ptr` advances once.
  - Requests from non-owners during BURST are ignored until IDLE.
- `req[i]` for i ≥ NUM_REQ does not exist. An out-of-range `rr_ptr` is unreachable.

## Timing
- Reset values (asynchronous):
  - state = IDLE
  - `owner`, `rr_ptr`, `cnt`, `rd_d1`, `id_d1` = 0
  - `gnt` = 0, `fifo_rd_en` = 0, `out_valid` = 0, `out_id` = 0
- Reset mid-burst aborts the burst immediately. A word popped in the last cycle before reset is not presented (`out_valid` forced to 0).
- Latency:
  - `req` rise (FIFO non-empty, arbiter idle) to `gnt`/first `fifo_rd_en`: 1 cycle.
  - `fifo_rd_en` to `out_valid`: 1 cycle.
- There is exactly one IDLE (dead) cycle between consecutive bursts. Peak throughput is MAX_BURST words per MAX_BURST+1 cycles.
- `gnt` falls in the cycle after the exit condition. `fifo_rd_en` is never high while `gnt` is 0.

## Test plan
- FIFO preloaded with 6 words (0x10..0x15), MAX_BURST=4, only `req[2]` held high:
  - pops 1-4 carry data 0x10..0x13 with `out_id`=2 on 4 consecutive cycles;
  - then `gnt` drops for 1 cycle;
  - then 0x14, 0x15;
  - then the burst ends on empty and `gnt`=0.
- MAX_BURST=1, FIFO holding 8 words, `req`=4'b1111 constant:
  - grant order 0,1,2,3,0,1,2,3;
  - `out_id` follows the same sequence;
  - `rr_ptr` wraps from 3 to 0.
- FIFO with 2 words, `req[1]` high, MAX_BURST=4:
  - 2 pops, then exit on `fifo_empty`, `gnt`=0;
  - pushing 1 word later re-grants requester 1 one cycle after `fifo_empty` falls.
- `req[0]` drops after its 2nd pop while `req[3]` is high:
  - no 3rd pop, one IDLE cycle, then requester 3 is granted;
  - `out_id` sequence 0,0,3,….
- `req` high while FIFO is empty:
  - `gnt`=0 and `fifo_rd_en`=0 for 20 cycles.
- `rst_n` asserted mid-burst while `fifo_rd_en`=1:
  - `gnt`, `fifo_rd_en`, `out_valid` are 0 immediately;
  - after release, arbitration restarts from requester 0.
